rand_sched: RTL and testbench
=============================

RAND_SCHED -- requirements
Module: rand_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one random generator.
REQ-002 Parameter SIZE_BITS, default 5: width of the random value.
REQ-003 Parameter MAX_RETRY, default 3: maximum re-fires per transaction when the repeat filter is compiled in.
REQ-004 clk  in  1  sole clock; all state changes on posedge clk.
REQ-005 resetN  in  1  reset, synchronous, active-low.
REQ-006 req  in  NUM_REQ  level request per requester; held high until its valid is seen.
REQ-007 rand_in  in  SIZE_BITS  latched output of the shared random generator.
REQ-008 rise  out  1  trigger to the generator; generator latches on its rising edge.
REQ-009 grant  out  NUM_REQ  one-hot owner of the current transaction; all zero when idle.
REQ-010 value  out  SIZE_BITS  delivered random value.
REQ-011 valid  out  1  one-cycle pulse; value is meaningful to the granted requester.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, FIRE, SETTLE and DONE, and all outputs SHALL be registered.
REQ-014 In IDLE with req nonzero, the arbiter SHALL select a requester round-robin, searching upward from (last served + 1) mod NUM_REQ, load grant, and go to FIRE.
REQ-015 FIRE SHALL drive rise=1 for exactly one cycle and then go to SETTLE.
REQ-016 SETTLE SHALL drive rise=0, register rand_in into value at the end of the cycle, and go to DONE (subject to REQ-026).
REQ-017 DONE SHALL drive valid=1 for one cycle, update the last-served pointer to the granted index, clear grant on exit, and return to IDLE.
REQ-018 Latency SHALL be fixed: with req first high in cycle N while IDLE, rise is high in N+1 and valid is high in N+3; the next FIRE is no earlier than N+5.
REQ-019 rise SHALL never be high in two consecutive cycles, so the generator sees a clean edge on every fire.
REQ-020 If the granted requester drops req during FIRE or SETTLE, the transaction SHALL abort: return to IDLE with no valid pulse, value unchanged, and pointer unchanged.
REQ-021 Requests arriving while busy SHALL be ignored until IDLE; simultaneous requests SHALL be resolved only by the round-robin order.
REQ-022 A requester whose req is still high in the IDLE cycle after its own DONE SHALL be treated as a new request, subject to round-robin order.
REQ-023 value SHALL hold its last delivered content between transactions.

Reset
REQ-024 While resetN=0 at a clock edge, the block SHALL set: state=IDLE, rise=0, grant=0, valid=0, busy=0, value=0, pointer=NUM_REQ-1 (requester 0 wins first), retry count=0, and last-value-valid flag=0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction with no valid pulse; reset has priority over all other transitions.

Configuration
REQ-026 With RAND_SCHED_REPEAT_FILTER_EN defined, in SETTLE, if the last-value-valid flag is set, rand_in equals the previously delivered value, and retry count < MAX_RETRY, the block SHALL increment the retry count and go to FIRE instead of DONE.
REQ-027 With RAND_SCHED_REPEAT_FILTER_EN defined, once the retry count reaches MAX_RETRY, the block SHALL accept the value; the retry count SHALL clear in DONE; the last-value-valid flag SHALL set on the first DONE.
REQ-028 Without RAND_SCHED_REPEAT_FILTER_EN, there SHALL be no retry logic, and SETTLE SHALL always go to DONE.

Verification
REQ-029 Single request: req=0001 at cycle 10, rand_in=7 in cycle 12 -> rise high in cycle 11, valid high in cycle 13 with grant=0001 and value=7.
REQ-030 Contention: req=1111 held constant -> grants follow 0001, 0010, 0100, 1000, 0001, with valid pulses 4 cycles apart.
REQ-031 Abort: req=0100 granted, req dropped in the FIRE cycle -> no valid pulse, busy low 2 cycles later, and the next req=0101 is granted to requester 0.
REQ-032 Reset mid-SETTLE: resetN=0 for one cycle -> next cycle all outputs 0, state IDLE, and a following req=0010 is served normally.
REQ-033 Filter enabled, MAX_RETRY=3: previous value=5, rand_in stuck at 5 -> 4 rise pulses in total, then valid with value=5; rand_in=5 then 9 -> 2 rise pulses, value=9.
REQ-034 Throughout all scenarios, checkers SHALL flag rise high in two consecutive cycles, grant not one-hot while busy, and valid high while grant=0.

Source files
------------

// File: rtl/rand_sched_if.sv
// Handshake bundle between requesters/generator and rand_sched.
// master = requester/generator side, slave = scheduler side.
interface rand_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_BITS = 5
);
  logic [NUM_REQ-1:0]   req;
  logic [SIZE_BITS-1:0] rand_in;
  logic                 rise;
  logic [NUM_REQ-1:0]   grant;
  logic [SIZE_BITS-1:0] value;
  logic                 valid;
  logic                 busy;

  modport master (
    output req,
    output rand_in,
    input  rise,
    input  grant,
    input  value,
    input  valid,
    input  busy
  );

  modport slave (
    input  req,
    input  rand_in,
    output rise,
    output grant,
    output value,
    output valid,
    output busy
  );
endinterface

// File: rtl/rand_sched.sv
// rand_sched: round-robin sharing of one random generator; rise 1 cycle and valid 3 cycles after req, no backpressure (req held until valid).
// Define RAND_SCHED_REPEAT_FILTER_EN to re-fire the generator (up to MAX_RETRY times) when it repeats the last delivered value.
module rand_sched #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_BITS = 5,
  parameter int MAX_RETRY = 3
) (
  input  logic         clk,
  input  logic         resetN,
  rand_sched_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRE   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Pointer starts at the top index so requester 0 wins the first arbitration.
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  logic [1:0]           state_q, state_d;
  logic                 rise_q, rise_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [SIZE_BITS-1:0] value_q, value_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;

  logic                 arb_hit;
  logic [IDX_W-1:0]     arb_idx;
  logic [IDX_W-1:0]     arb_cand;
  logic                 owner_drop;
  logic                 abort;
  logic                 refire;

  assign owner_drop = ~|(bus.req & grant_q);
  assign abort      = owner_drop && ((state_q == S_FIRE) || (state_q == S_SETTLE));

`ifdef RAND_SCHED_REPEAT_FILTER_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               last_vld_q, last_vld_d;

  assign refire = last_vld_q && (bus.rand_in == value_q) &&
                  (retry_q < RETRY_W'(MAX_RETRY));

  always_comb begin
    retry_d    = retry_q;
    last_vld_d = last_vld_q;
    if (abort) begin
      retry_d = '0;
    end else if ((state_q == S_SETTLE) && refire) begin
      retry_d = retry_q + 1'b1;
    end else if (state_q == S_DONE) begin
      retry_d    = '0;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      retry_q    <= '0;
      last_vld_q <= 1'b0;
    end else begin
      retry_q    <= retry_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign refire = 1'b0;
`endif

  // Round-robin search upward from the entry after the last served one.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    arb_cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!arb_hit && bus.req[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rise_d    = 1'b0;
    valid_d   = 1'b0;
    grant_d   = grant_q;
    value_d   = value_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;

    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          state_d          = S_FIRE;
          rise_d           = 1'b1;
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
          gnt_idx_d        = arb_idx;
        end
      end
      S_FIRE: begin
        if (abort) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (refire) begin
          // Came from SETTLE with rise low, so the new pulse is a clean edge.
          state_d = S_FIRE;
          rise_d  = 1'b1;
        end else begin
          state_d = S_DONE;
          valid_d = 1'b1;
          value_d = bus.rand_in;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = gnt_idx_q;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      rise_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      grant_q   <= '0;
      value_q   <= '0;
      ptr_q     <= PTR_RST;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rise_q    <= rise_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      grant_q   <= grant_d;
      value_q   <= value_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign bus.rise  = rise_q;
  assign bus.grant = grant_q;
  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rand_sched.sv
// Directed bench for rand_sched with a grant/value scoreboard and continuous protocol monitors.
// Filter scenarios are compiled when RAND_SCHED_REPEAT_FILTER_EN is defined.
module tb_rand_sched;

  logic clk;
  logic resetN;

  rand_sched_if bus ();

  rand_sched dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [4:0] value;
  } exp_t;

  exp_t exp_q [$];

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   rise_cnt  = 0;
  int   valid_cnt = 0;
  logic rise_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitors and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    chk("rise_consecutive", 32'(bus.rise & rise_prev), 0);
    rise_prev = bus.rise;
    if (bus.rise === 1'b1) rise_cnt++;
    if (bus.busy === 1'b1) chk("grant_onehot_busy", 32'($onehot(bus.grant)), 1);
    if (bus.valid === 1'b1) begin
      valid_cnt++;
      chk("valid_grant_nonzero", 32'(bus.grant != 4'd0), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(bus.valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant", 32'(bus.grant), 32'(e.grant));
        chk("sb_value", 32'(bus.value), 32'(e.value));
      end
    end
  end

  task automatic wait_valid(input int chg_step, input logic [4:0] rv_b, output bit got);
    got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == chg_step) bus.rand_in = rv_b;
      if (bus.valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_txn(input string tag, input logic [3:0] r,
                         input logic [4:0] rv_a, input logic [4:0] rv_b, input int chg_step,
                         input logic [3:0] exp_g, input logic [4:0] exp_v,
                         input int exp_rises, input int exp_lat);
    exp_t e;
    int   c0;
    int   r0;
    bit   got;
    e.grant = exp_g;
    e.value = exp_v;
    exp_q.push_back(e);
    bus.rand_in = rv_a;
    bus.req     = r;
    c0 = cyc;
    r0 = rise_cnt;
    step();
    chk({tag, "_rise_n1"}, 32'(bus.rise), 1);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(exp_g));
    wait_valid(chg_step - 1, rv_b, got);
    chk({tag, "_valid_seen"}, 32'(got), 1);
    chk({tag, "_latency"}, 32'(cyc - c0), 32'(exp_lat));
    chk({tag, "_rises"}, 32'(rise_cnt - r0), 32'(exp_rises));
    bus.req = '0;
    step();
    chk({tag, "_valid_pulse"}, 32'(bus.valid), 0);
    chk({tag, "_busy_after"}, 32'(bus.busy), 0);
    chk({tag, "_value_hold"}, 32'(bus.value), 32'(exp_v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c0;
    int   prev;
    int   vc0;
    bit   got;
    exp_t e;

    resetN      = 1'b0;
    bus.req     = '0;
    bus.rand_in = '0;
    repeat (3) step();
    chk("rst_rise",  32'(bus.rise),  0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_busy",  32'(bus.busy),  0);
    chk("rst_value", 32'(bus.value), 0);
    resetN = 1'b1;
    step();
    step();

    // Contention: all four requesters held high, served in rotation.
    bus.rand_in = 5'd10;
    bus.req     = 4'b1111;
    c0   = cyc;
    prev = c0;
    for (int k = 0; k < 5; k++) begin
      e.grant = 4'(1 << (k % 4));
      e.value = 5'(10 + k);
      exp_q.push_back(e);
      wait_valid(-1, 5'd0, got);
      chk("contend_valid_seen", 32'(got), 1);
      chk("contend_grant", 32'(bus.grant), 32'(e.grant));
      chk("contend_gap", 32'(cyc - prev), (k == 0) ? 32'd3 : 32'd4);
      prev = cyc;
      bus.rand_in = 5'(11 + k);
    end
    bus.req = '0;
    step();
    step();
    chk("contend_idle_busy", 32'(bus.busy), 0);

    // Single request; pointer is at 0 so the search wraps back to 0.
    run_txn("single", 4'b0001, 5'd7, 5'd7, 0, 4'b0001, 5'd7, 1, 3);
    step();
    chk("single_value_idle", 32'(bus.value), 7);

    // Reset asserted while the transaction sits in SETTLE.
    bus.req     = 4'b0010;
    bus.rand_in = 5'd3;
    vc0 = valid_cnt;
    step();
    step();
    chk("midrst_in_settle", 32'(bus.busy), 1);
    resetN = 1'b0;
    step();
    chk("midrst_rise",  32'(bus.rise),  0);
    chk("midrst_grant", 32'(bus.grant), 0);
    chk("midrst_valid", 32'(bus.valid), 0);
    chk("midrst_busy",  32'(bus.busy),  0);
    chk("midrst_value", 32'(bus.value), 0);
    resetN  = 1'b1;
    bus.req = '0;
    step();
    chk("midrst_no_valid", 32'(valid_cnt - vc0), 0);
    run_txn("after_rst", 4'b0010, 5'd20, 5'd20, 0, 4'b0010, 5'd20, 1, 3);
    run_txn("serve_r3", 4'b1000, 5'd21, 5'd21, 0, 4'b1000, 5'd21, 1, 3);

    // Abort: owner drops req during FIRE.
    bus.req     = 4'b0100;
    bus.rand_in = 5'd2;
    vc0 = valid_cnt;
    step();
    chk("abort_rise",  32'(bus.rise),  1);
    chk("abort_grant", 32'(bus.grant), 32'(4'b0100));
    bus.req = '0;
    step();
    step();
    chk("abort_busy",      32'(bus.busy),  0);
    chk("abort_grant_clr", 32'(bus.grant), 0);
    step();
    step();
    chk("abort_no_valid", 32'(valid_cnt - vc0), 0);
    chk("abort_value",    32'(bus.value), 21);
    run_txn("post_abort", 4'b0101, 5'd22, 5'd22, 0, 4'b0001, 5'd22, 1, 3);

`ifdef RAND_SCHED_REPEAT_FILTER_EN
    run_txn("filt_first",  4'b0001, 5'd5, 5'd5, 0, 4'b0001, 5'd5, 1, 3);
    run_txn("filt_stuck",  4'b0001, 5'd5, 5'd5, 0, 4'b0001, 5'd5, 4, 9);
    run_txn("filt_change", 4'b0001, 5'd5, 5'd9, 3, 4'b0001, 5'd9, 2, 5);
`else
    run_txn("nofilt_repeat", 4'b0001, 5'd22, 5'd22, 0, 4'b0001, 5'd22, 1, 3);
`endif

    step();
    step();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
